// File: rtl/systolic_pkg.sv
// Shared constants and types for the 3x3 weight-stationary systolic array sequencer.
package systolic_pkg;
  localparam int ARR_N          = 3;
  localparam int STREAM_CYCLES  = 2 * ARR_N - 1;
  localparam int DEFAULT_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } ctrl_state_t;
endpackage

// File: rtl/systolic_skew_feed.sv
// Combinational diagonal skew: row r of the west edge gets A[t-r][r] while 0 <= t-r < N.
import systolic_pkg::*;

module systolic_skew_feed #(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int N      = ARR_N
) (
  input  logic [N*N*DATA_W-1:0] act,
  input  logic [7:0]            t,
  output logic [N*DATA_W-1:0]   west
);

  always_comb begin
    west = '0;
    for (int r = 0; r < N; r++) begin
      for (int k = 0; k < N; k++) begin
        if (t == 8'(k + r)) begin
          west[r*DATA_W +: DATA_W] = act[(k*N + r)*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule

// File: rtl/systolic_ctrl.sv
// Job sequencer for the 3x3 systolic array: weight load, skewed activation stream, drain, done.
// Every output is registered from the next-state decode, so it changes on the edge that enters a state.
import systolic_pkg::*;

module systolic_ctrl #(
  parameter int DATA_W       = DEFAULT_DATA_W,
  parameter int DRAIN_CYCLES = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  reuse_w,
  input  logic [9*DATA_W-1:0]   weight_in,
  input  logic [9*DATA_W-1:0]   act_in,
  output logic                  busy,
  output logic                  done,
  output logic                  weight_en,
  output logic                  compute,
  output logic [DATA_W-1:0]     inp_weight0,
  output logic [DATA_W-1:0]     inp_weight1,
  output logic [DATA_W-1:0]     inp_weight2,
  output logic [DATA_W-1:0]     inp_weight3,
  output logic [DATA_W-1:0]     inp_weight4,
  output logic [DATA_W-1:0]     inp_weight5,
  output logic [DATA_W-1:0]     inp_weight6,
  output logic [DATA_W-1:0]     inp_weight7,
  output logic [DATA_W-1:0]     inp_weight8,
  output logic [DATA_W-1:0]     inp_west0,
  output logic [DATA_W-1:0]     inp_west3,
  output logic [DATA_W-1:0]     inp_west6,
  output ctrl_state_t           state_dbg
);

  ctrl_state_t               state, state_nxt;
  logic [7:0]                cnt, cnt_nxt;
  logic                      accept;
  logic                      w_valid;
  logic [9*DATA_W-1:0]       act_buf, act_sel;
  logic [ARR_N*DATA_W-1:0]   west_nxt;
  logic [DATA_W-1:0]         w_reg [9];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = (reuse_w && w_valid) ? STREAM : LOAD_W;
        end
      end
      LOAD_W:  state_nxt = STREAM;
      STREAM:  if (cnt == 8'(STREAM_CYCLES - 1)) state_nxt = DRAIN;
      DRAIN:   if (cnt == 8'(DRAIN_CYCLES - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // The counter restarts on every state entry, so it is t inside STREAM.
    cnt_nxt = (state_nxt != state) ? 8'd0 : cnt + 8'd1;
  end

  // On the accept edge the buffer is not yet written, so feed the skew from the live input.
  assign act_sel = accept ? act_in : act_buf;

  systolic_skew_feed #(.DATA_W(DATA_W), .N(ARR_N)) u_skew (
    .act  (act_sel),
    .t    (cnt_nxt),
    .west (west_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      weight_en <= 1'b0;
      compute   <= 1'b0;
      w_valid   <= 1'b0;
      act_buf   <= '0;
      inp_west0 <= '0;
      inp_west3 <= '0;
      inp_west6 <= '0;
      for (int i = 0; i < 9; i++) w_reg[i] <= '0;
    end else begin
      if (accept) act_buf <= act_in;
      if (accept && state_nxt == LOAD_W) begin
        for (int i = 0; i < 9; i++) w_reg[i] <= weight_in[i*DATA_W +: DATA_W];
      end
      if (state == LOAD_W) w_valid <= 1'b1;
      busy      <= (state_nxt != IDLE);
      done      <= (state_nxt == DONE);
      weight_en <= (state_nxt == LOAD_W);
      compute   <= (state_nxt == STREAM) || (state_nxt == DRAIN);
      if (state_nxt == STREAM) begin
        inp_west0 <= west_nxt[0*DATA_W +: DATA_W];
        inp_west3 <= west_nxt[1*DATA_W +: DATA_W];
        inp_west6 <= west_nxt[2*DATA_W +: DATA_W];
      end else begin
        inp_west0 <= '0;
        inp_west3 <= '0;
        inp_west6 <= '0;
      end
    end
  end

  assign inp_weight0 = w_reg[0];
  assign inp_weight1 = w_reg[1];
  assign inp_weight2 = w_reg[2];
  assign inp_weight3 = w_reg[3];
  assign inp_weight4 = w_reg[4];
  assign inp_weight5 = w_reg[5];
  assign inp_weight6 = w_reg[6];
  assign inp_weight7 = w_reg[7];
  assign inp_weight8 = w_reg[8];
  assign state_dbg   = state;

endmodule

// File: doc/systolic_ctrl.md
# systolic_ctrl

Sequencer for the 3x3 weight-stationary `systolic_array`. It captures a 3x3 weight matrix and a 3x3 activation matrix on a start handshake, then drives a one-cycle weight load. It then feeds the activations diagonally skewed into the west edge (`inp_west0/3/6`) with `compute` asserted, holds `compute` through a drain window, and reports completion. It sits between the host/register interface and the array, replacing hand-driven stimulus.

## Interface
Parameters:
- `DATA_W`, 32, element width
- `DRAIN_CYCLES`, 5, cycles `compute` stays high after the last skewed input; legal range 1..255

Ports:
- `clk` input 1: the block's single clock
- `rst` input 1: synchronous, active-high reset
- `start` input 1: request a job; accepted only when `busy`=0
- `reuse_w` input 1: sampled with `start`; 1 skips the weight load if the held weights are valid
- `weight_in` input 9*DATA_W: W[0..8], row-major, element i at bits [i*DATA_W +: DATA_W]; sampled at accept
- `act_in` input 9*DATA_W: A[r][c] at index 3r+c; sampled at accept
- `busy` output 1: job in progress
- `done` output 1: one-cycle completion pulse
- `weight_en` output 1: to the array
- `compute` output 1: to the array
- `inp_weight0..8` output DATA_W each: to the array
- `inp_west0`, `inp_west3`, `inp_west6` output DATA_W each: to the array

## Operation
- **Reset values.** `rst`=1 sets state IDLE and all outputs to 0, including weights and west data. It also clears internal `w_valid`. Reset mid-job aborts immediately with no `done` pulse.
- **State machine.** States are IDLE, LOAD_W, STREAM, DRAIN, DONE. All outputs are registered.
- **IDLE.**
  - On `start`=1, latch `act_in` into the activation buffer and set `busy`.
  - If `reuse_w`=1 and `w_valid`=1, go to STREAM and leave `weight_in` unsampled.
  - Otherwise latch `weight_in` and go to LOAD_W.
- **LOAD_W.** Lasts 1 cycle. `weight_en`=1 and `inp_weight*` hold the latched W. Sets `w_valid`. Next state is STREAM.
  - `inp_weight*` keep their values after LOAD_W until the next load or reset.
- **STREAM.** Lasts 5 cycles (2N-1), with t = 0..4. `compute`=1.
  - West input for row r (port `inp_west{3r}`) is A[t-r][r] when 0 ≤ t-r ≤ 2, else 0.
  - Example with A=[[1,2,3],[4,5,6],[7,8,9]]: (w0,w3,w6) per cycle is (1,0,0), (4,2,0), (7,5,3), (0,8,6), (0,0,9).
- **DRAIN.** Lasts `DRAIN_CYCLES` cycles. `compute`=1 and all west inputs are 0.
- **DONE.** Lasts 1 cycle. `done`=1, `compute`=0, `busy` still 1. Next state is IDLE, with `busy` falling.
- **Illegal or stray input.** `start` while `busy`=1 is ignored; no queueing. Inputs are not re-sampled mid-job. Changing `act_in` or `weight_in` during a job has no effect.
- **Arithmetic.** Data passes through unmodified at `DATA_W`. The cycle counter is 8 bits and is cleared on every state entry.

## Timing
- Cycle 0 is the clock edge that accepts `start`. Registered outputs change on that edge.
- **Full load, default drain.**
  - c0–c1: `weight_en`=1 (LOAD_W).
  - c1–c5 edges: STREAM outputs, `compute`=1.
  - Then 5 DRAIN cycles.
  - `done` is high in the 12th cycle after accept.
  - `busy` is high for 12 cycles.
- **Reuse.** Every event is one cycle earlier and `weight_en` never rises.
- **General latency.** Accept to `done` is 1 + 5 + `DRAIN_CYCLES` + 1 cycles, minus 1 when weights are reused.
- **Back-to-back jobs.** `start` held high during DONE is not accepted. It is accepted on the first IDLE cycle, giving a minimum one-cycle gap with `busy`=0.
- **Reset priority.** `rst` takes priority over `start` in the same cycle.

## Structure
- **Package `systolic_pkg`:**
  - `ARR_N`=3
  - `STREAM_CYCLES`=2*ARR_N-1
  - enum `ctrl_state_t` (IDLE, LOAD_W, STREAM, DRAIN, DONE)
  - default `DATA_W`
- **Sub-module `systolic_skew_feed`:** combinational selection of west values from the activation buffer and t. It is registered by the parent. It is kept separate so the skew rule can be unit-tested and reused for larger N.
- **Parent `systolic_ctrl`:** FSM, counter, buffers, `w_valid`.

## Test plan
1. **Reset and idle.** Hold `rst` 5 cycles, then release with no `start`. All outputs stay 0 and `busy`=0 for 20 cycles.
2. **Full job, default drain.**
   - Stimulus: W=1..9, A=[[1,2,3],[4,5,6],[7,8,9]], `start` for 1 cycle.
   - `weight_en` pulses 1 cycle and `inp_weight0..8` = 1..9.
   - West sequence is (1,0,0), (4,2,0), (7,5,3), (0,8,6), (0,0,9), then 5 zero cycles with `compute`=1.
   - `done` is high in the 12th cycle after accept.
   - A scoreboard using a `systolic_array` instance checks the product.
3. **Weight reuse.**
   - Second job with `reuse_w`=1, A=identity, and `weight_in` driven to 0xDEAD.
   - No `weight_en`; `inp_weight*` remain 1..9.
   - `done` arrives at 11 cycles.
   - After a reset, the same request performs a full load.
4. **Start during busy.** Pulse `start` at c3 and during DONE. Both are ignored, and exactly one `done` pulse occurs.
5. **Reset mid-STREAM.** Assert `rst` at stream t=2. Next cycle all outputs are 0, with no `done`. A subsequent `reuse_w`=1 job performs LOAD_W.
6. **Drain bounds.** Run with `DRAIN_CYCLES`=1 and with 255. `compute` high time is 5+1 and 5+255 cycles respectively, and `done` latency matches the formula.
